// File: rtl/bus_arbiter.sv
// Sixteen-master round-robin bus arbiter with transfer-boundary hand-off, lock support and parking.
// Optional forced lock release is enabled by defining ARB_LOCK_TIMEOUT_EN.
module bus_arbiter #(
    parameter int unsigned DEF_M  = 0,
    parameter int unsigned TO_CYC = 255
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [15:0] MxREQ,
    input  logic        MmLK,
    input  logic        MmLST,
    input  logic [2:0]  MmMOD,
    input  logic        MsRDY,
    output logic [15:0] AmCMUX,
    output logic [15:0] AmDMUX,
    output logic [3:0]  AmOWN,
    output logic        AmLKTO
);

    typedef enum logic [1:0] {StPark, StOwn, StLocked} state_e;

    localparam logic [3:0]  DefIdx = 4'(DEF_M);
    localparam logic [15:0] DefHot = 16'(1) << DEF_M;

    state_e      state_q;
    logic [3:0]  ptr_q;
    logic        ap;
    logic        force_rel;
    logic        win_found;
    logic [3:0]  win_idx;
    logic [3:0]  cand;

    // Search starts just after the last granted requester, so that master is considered last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int i = 1; i <= 16; i++) begin
            cand = ptr_q + 4'(i);
            if (!win_found && MxREQ[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        ap = 1'b0;
        unique case (state_q)
            StPark:   ap = 1'b1;
            StOwn:    ap = (MmLST | (MmMOD == 3'b000)) & ~MmLK;
            StLocked: ap = ~MmLK | force_rel;
            default:  ap = 1'b1;
        endcase
    end

`ifdef ARB_LOCK_TIMEOUT_EN
    logic [7:0] to_cnt_q;
    logic       others;

    assign others    = |(MxREQ & ~AmCMUX);
    assign force_rel = (state_q == StLocked) && (to_cnt_q == 8'(TO_CYC)) && others;

    // Counter runs every cycle in LOCKED and saturates at the limit until a rival appears.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            to_cnt_q <= 8'd0;
            AmLKTO   <= 1'b0;
        end else begin
            AmLKTO <= force_rel & MsRDY;
            if (state_q != StLocked) begin
                to_cnt_q <= 8'd0;
            end else if (to_cnt_q != 8'(TO_CYC)) begin
                to_cnt_q <= to_cnt_q + 8'd1;
            end
        end
    end
`else
    assign force_rel = 1'b0;
    assign AmLKTO    = 1'b0;
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= StPark;
            ptr_q   <= DefIdx;
            AmCMUX  <= DefHot;
            AmDMUX  <= DefHot;
            AmOWN   <= DefIdx;
        end else if (MsRDY) begin
            AmDMUX <= AmCMUX;
            if (state_q == StOwn && MmLK) begin
                state_q <= StLocked;
            end else if (ap) begin
                if (win_found) begin
                    state_q <= StOwn;
                    ptr_q   <= win_idx;
                    AmCMUX  <= 16'(1) << win_idx;
                    AmOWN   <= win_idx;
                end else begin
                    state_q <= StPark;
                    AmCMUX  <= DefHot;
                    AmOWN   <= DefIdx;
                end
            end
        end
    end

endmodule
